// File: rtl/loop_counter.sv
// loop_counter: programmable up/down loop counter with
// free-run, saturate, reload and one-shot terminal modes.
module loop_counter #(
  parameter int WORD_SIZE  = 32,
  parameter int STEP_WIDTH = 8,
  parameter int NEG_EDGE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WORD_SIZE-1:0]  load_data,
  input  logic [WORD_SIZE-1:0]  limit,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic                  count_enable,
  output logic [WORD_SIZE-1:0]  count,
  output logic                  at_limit,
  output logic                  done,
  output logic                  overflow
);

  localparam int XW = WORD_SIZE + 1;
  localparam int PADW = XW - STEP_WIDTH;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [1:0] M_FREE    = 2'b00;
  localparam logic [1:0] M_SAT     = 2'b01;
  localparam logic [1:0] M_RELOAD  = 2'b10;
  localparam logic [1:0] M_ONESHOT = 2'b11;

  logic [WORD_SIZE-1:0] count_q, count_d;
  logic [WORD_SIZE-1:0] reload_q, reload_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic [0:0]           state_q, state_d;

  logic [XW-1:0]        step_x;
  logic [XW-1:0]        sum_x;
  logic [XW-1:0]        diff_x;
  logic [XW-1:0]        next_x;
  logic [WORD_SIZE-1:0] next_w;
  logic                 carry;
  logic                 step_nz;
  logic                 hit_up;
  logic                 hit_dn;
  logic                 hit;
  logic                 advance;

  // Extended-width arithmetic: top bit carries the wrap indication
  always_comb begin
    step_x  = {{PADW{1'b0}}, step};
    sum_x   = {1'b0, count_q} + step_x;
    diff_x  = {1'b0, count_q} - step_x;
    next_x  = dir ? diff_x : sum_x;
    next_w  = next_x[WORD_SIZE-1:0];
    carry   = next_x[WORD_SIZE];
    step_nz = |step;
    hit_up  = sum_x >= {1'b0, limit};
    hit_dn  = diff_x[WORD_SIZE] ||
              (diff_x[WORD_SIZE-1:0] <= limit);
    hit     = step_nz & (dir ? hit_dn : hit_up);
    advance = count_enable & step_nz &
              (state_q == ST_RUN);
  end

  // Next-state selection: clear beats load beats counting
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    state_d  = state_q;
    if (clear) begin
      count_d  = '0;
      reload_d = '0;
      ovf_d    = 1'b0;
      state_d  = ST_RUN;
    end else if (load) begin
      count_d  = load_data;
      reload_d = load_data;
      ovf_d    = 1'b0;
      state_d  = ST_RUN;
    end else if (advance) begin
      unique case (mode)
        M_FREE: begin
          count_d = next_w;
          if (carry) begin
            done_d = 1'b1;
            ovf_d  = 1'b1;
          end
        end
        M_SAT: begin
          if (hit) begin
            count_d = limit;
            done_d  = (count_q != limit);
          end else begin
            count_d = next_w;
          end
        end
        M_RELOAD: begin
          if (hit) begin
            count_d = reload_q;
            done_d  = 1'b1;
          end else begin
            count_d = next_w;
          end
        end
        M_ONESHOT: begin
          if (hit) begin
            count_d = limit;
            done_d  = 1'b1;
            state_d = ST_HALT;
          end else begin
            count_d = next_w;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  generate
    if (NEG_EDGE != 0) begin : g_neg
      // State registers updated on the falling clock edge
      always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
          count_q  <= '0;
          reload_q <= '0;
          done_q   <= 1'b0;
          ovf_q    <= 1'b0;
          state_q  <= ST_RUN;
        end else begin
          count_q  <= count_d;
          reload_q <= reload_d;
          done_q   <= done_d;
          ovf_q    <= ovf_d;
          state_q  <= state_d;
        end
      end
    end else begin : g_pos
      // State registers updated on the rising clock edge
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          count_q  <= '0;
          reload_q <= '0;
          done_q   <= 1'b0;
          ovf_q    <= 1'b0;
          state_q  <= ST_RUN;
        end else begin
          count_q  <= count_d;
          reload_q <= reload_d;
          done_q   <= done_d;
          ovf_q    <= ovf_d;
          state_q  <= state_d;
        end
      end
    end
  endgenerate

  // Outputs: registered state plus a live limit compare
  always_comb begin
    count    = count_q;
    done     = done_q;
    overflow = ovf_q;
    at_limit = (count_q == limit);
  end

endmodule

// File: tb/tb_loop_counter.sv
// tb_loop_counter: table vectors, corner sequences and
// randomized checks against an integer reference model.
module tb_loop_counter;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       load;
  logic [7:0] load_data;
  logic [7:0] limit;
  logic [7:0] step;
  logic       dir;
  logic [1:0] mode;
  logic       count_enable;

  logic [7:0] cnt_n, cnt_p;
  logic       at_n, at_p;
  logic       done_n, done_p;
  logic       ovf_n, ovf_p;

  int nvec = 0;
  int nmis = 0;

  loop_counter #(
    .WORD_SIZE(8), .STEP_WIDTH(8), .NEG_EDGE(1)
  ) u_neg (
    .clk(clk), .rst(rst), .clear(clear), .load(load),
    .load_data(load_data), .limit(limit), .step(step),
    .dir(dir), .mode(mode), .count_enable(count_enable),
    .count(cnt_n), .at_limit(at_n), .done(done_n),
    .overflow(ovf_n)
  );

  loop_counter #(
    .WORD_SIZE(8), .STEP_WIDTH(8), .NEG_EDGE(0)
  ) u_pos (
    .clk(clk), .rst(rst), .clear(clear), .load(load),
    .load_data(load_data), .limit(limit), .step(step),
    .dir(dir), .mode(mode), .count_enable(count_enable),
    .count(cnt_p), .at_limit(at_p), .done(done_p),
    .overflow(ovf_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       ld;
    logic [7:0] d;
    logic [7:0] lim;
    logic [7:0] stp;
    logic       dr;
    logic [1:0] md;
    logic       en;
    logic [7:0] ec;
    logic       ed;
    logic       eo;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  int m_cnt, m_rel;
  bit m_done, m_ovf, m_halt;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic add(logic clr, logic ld, logic [7:0] d,
                     logic [7:0] lim, logic [7:0] stp,
                     logic dr, logic [1:0] md, logic en,
                     logic [7:0] ec, logic ed, logic eo);
    vec_t v;
    v.clr = clr; v.ld = ld; v.d = d; v.lim = lim;
    v.stp = stp; v.dr = dr; v.md = md; v.en = en;
    v.ec = ec; v.ed = ed; v.eo = eo;
    tbl.push_back(v);
  endtask

  task automatic drive(logic clr, logic ld, logic [7:0] d,
                       logic [7:0] lim, logic [7:0] stp,
                       logic dr, logic [1:0] md, logic en);
    clear = clr; load = ld; load_data = d; limit = lim;
    step = stp; dir = dr; mode = md; count_enable = en;
  endtask

  task automatic m_reset();
    m_cnt = 0; m_rel = 0; m_done = 0;
    m_ovf = 0; m_halt = 0;
  endtask

  // one active edge of the reference, from current inputs
  task automatic m_edge();
    int nx, lim, s;
    bit hit, wrap;
    lim = int'(limit);
    s = int'(step);
    m_done = 0;
    if (clear) begin
      m_reset();
    end else if (load) begin
      m_cnt = int'(load_data);
      m_rel = m_cnt;
      m_ovf = 0;
      m_halt = 0;
    end else if (count_enable && !m_halt && s != 0) begin
      nx = dir ? m_cnt - s : m_cnt + s;
      wrap = (nx < 0) || (nx > 255);
      hit = dir ? ((nx < 0) || (nx <= lim)) : (nx >= lim);
      nx = (nx + 256) % 256;
      case (mode)
        2'd0: begin
          m_cnt = nx;
          if (wrap) begin m_done = 1; m_ovf = 1; end
        end
        2'd1: begin
          if (hit) begin
            m_done = (m_cnt != lim);
            m_cnt = lim;
          end else m_cnt = nx;
        end
        2'd2: begin
          if (hit) begin m_cnt = m_rel; m_done = 1; end
          else m_cnt = nx;
        end
        default: begin
          if (hit) begin
            m_cnt = lim; m_done = 1; m_halt = 1;
          end else m_cnt = nx;
        end
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 8'h00, 0, 2'd0, 0);

    add(0,1,8'hFE,8'd0,8'd1,0,2'd0,0, 8'hFE,0,0);
    add(0,0,8'h00,8'd0,8'd1,0,2'd0,1, 8'hFF,0,0);
    add(0,0,8'h00,8'd0,8'd1,0,2'd0,1, 8'h00,1,1);
    add(0,0,8'h00,8'd0,8'd1,0,2'd0,1, 8'h01,0,1);
    add(0,1,8'h80,8'd0,8'd0,0,2'd0,0, 8'h80,0,0);
    add(0,0,8'h00,8'd0,8'd0,0,2'd0,1, 8'h80,0,0);
    add(0,1,8'h00,8'd10,8'd3,0,2'd1,0, 8'd0,0,0);
    add(0,0,8'h00,8'd10,8'd3,0,2'd1,1, 8'd3,0,0);
    add(0,0,8'h00,8'd10,8'd3,0,2'd1,1, 8'd6,0,0);
    add(0,0,8'h00,8'd10,8'd3,0,2'd1,1, 8'd9,0,0);
    add(0,0,8'h00,8'd10,8'd3,0,2'd1,1, 8'd10,1,0);
    add(0,0,8'h00,8'd10,8'd3,0,2'd1,1, 8'd10,0,0);
    add(0,1,8'd9,8'd3,8'd2,1,2'd2,0, 8'd9,0,0);
    add(0,0,8'd0,8'd3,8'd2,1,2'd2,1, 8'd7,0,0);
    add(0,0,8'd0,8'd3,8'd2,1,2'd2,1, 8'd5,0,0);
    add(0,0,8'd0,8'd3,8'd2,1,2'd2,1, 8'd9,1,0);
    add(0,0,8'd0,8'd3,8'd2,1,2'd2,1, 8'd7,0,0);
    add(0,1,8'd0,8'd2,8'd1,0,2'd3,0, 8'd0,0,0);
    add(0,0,8'd0,8'd2,8'd1,0,2'd3,1, 8'd1,0,0);
    add(0,0,8'd0,8'd2,8'd1,0,2'd3,1, 8'd2,1,0);
    add(0,0,8'd0,8'd2,8'd1,0,2'd3,1, 8'd2,0,0);
    add(0,0,8'd0,8'd2,8'd1,0,2'd3,1, 8'd2,0,0);
    add(0,1,8'd5,8'd2,8'd1,0,2'd3,0, 8'd5,0,0);
    add(0,0,8'd0,8'd2,8'd1,0,2'd3,1, 8'd2,1,0);
    add(0,0,8'd0,8'd2,8'd1,0,2'd3,1, 8'd2,0,0);
    add(1,1,8'h55,8'd2,8'd1,0,2'd3,1, 8'd0,0,0);
    add(0,1,8'h01,8'd0,8'd2,1,2'd0,0, 8'h01,0,0);
    add(0,0,8'h00,8'd0,8'd2,1,2'd0,1, 8'hFF,1,1);
    add(0,0,8'h00,8'd0,8'd2,1,2'd0,1, 8'hFD,0,1);
    add(1,0,8'h00,8'd0,8'd2,1,2'd0,1, 8'h00,0,0);

    repeat (2) tick();
    chk("reset_count", cnt_n, 8'h00);
    chk("reset_done", done_n, 1'b0);
    chk("reset_ovf", ovf_n, 1'b0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].ld, tbl[i].d, tbl[i].lim,
            tbl[i].stp, tbl[i].dr, tbl[i].md, tbl[i].en);
      tick();
      chk($sformatf("tbl%0d_count", i), cnt_n, tbl[i].ec);
      chk($sformatf("tbl%0d_done", i), done_n, tbl[i].ed);
      chk($sformatf("tbl%0d_ovf", i), ovf_n, tbl[i].eo);
      chk($sformatf("tbl%0d_pos_count", i), cnt_p,
          tbl[i].ec);
    end

    // async reset between edges, mid-count with overflow set
    drive(0, 1, 8'hFE, 8'd0, 8'd1, 0, 2'd0, 0);
    tick();
    drive(0, 0, 8'h00, 8'd0, 8'd1, 0, 2'd0, 1);
    tick();
    tick();
    chk("pre_rst_ovf", ovf_n, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", cnt_n, 8'h00);
    chk("async_rst_done", done_n, 1'b0);
    chk("async_rst_ovf", ovf_n, 1'b0);
    chk("async_rst_pos_count", cnt_p, 8'h00);
    chk("async_rst_pos_ovf", ovf_p, 1'b0);
    rst = 1'b1;
    tick();
    chk("post_rst_count", cnt_n, 8'h01);
    chk("post_rst_pos_count", cnt_p, 8'h01);
    chk("at_limit_off", at_n, 1'b0);
    limit = 8'h01;
    #1;
    chk("at_limit_live", at_n, 1'b1);

    // randomized run against the reference model
    for (int k = 0; k < 400; k++) begin
      logic [7:0] st;
      st = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                                       : 8'($urandom_range(0, 4));
      drive((k == 0) || ($urandom_range(0, 39) == 0),
            $urandom_range(0, 15) == 0,
            8'($urandom), 8'($urandom), st,
            1'($urandom), 2'($urandom),
            $urandom_range(0, 4) != 0);
      m_edge();
      tick();
      chk($sformatf("rnd%0d_count", k), cnt_n, m_cnt[7:0]);
      chk($sformatf("rnd%0d_done", k), done_n, m_done);
      chk($sformatf("rnd%0d_ovf", k), ovf_n, m_ovf);
      chk($sformatf("rnd%0d_at", k), at_n,
          m_cnt[7:0] == limit);
      chk($sformatf("rnd%0d_pos_count", k), cnt_p,
          m_cnt[7:0]);
      chk($sformatf("rnd%0d_pos_done", k), done_p, m_done);
    end

    // active edge selection: rising vs falling
    drive(1, 0, 8'h00, 8'd0, 8'd1, 0, 2'd0, 0);
    tick();
    drive(0, 1, 8'h42, 8'd0, 8'd1, 0, 2'd0, 0);
    @(posedge clk);
    #1;
    chk("edge_pos_loaded", cnt_p, 8'h42);
    chk("edge_neg_waits", cnt_n, 8'h00);
    @(negedge clk);
    #1;
    chk("edge_neg_loaded", cnt_n, 8'h42);
    drive(0, 0, 8'h00, 8'd0, 8'd1, 0, 2'd0, 1);
    @(posedge clk);
    #1;
    chk("edge_pos_inc", cnt_p, 8'h43);
    chk("edge_neg_hold", cnt_n, 8'h42);
    @(negedge clk);
    #1;
    chk("edge_neg_inc", cnt_n, 8'h43);
    chk("edge_pos_hold", cnt_p, 8'h43);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
